// File: rtl/multiexp_pnt_scl_feeder.sv
// Purpose: buffers N {point, scalar} pairs once, then replays the whole set DAT_BITS times.
// Latency: first replay beat is valid 2 cycles after the last load beat handshakes.
// Backpressure: replay holds data under !rdy through a 1-entry skid; load rdy is high only while loading.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start, i_num_in        start pulse (IDLE only) and pair count N
//   i_load_*                 host load stream (sink); mod/ctl/err are accepted but not stored
//   o_pnt_scl_*              replay stream (source) towards the multiexp core
//   o_busy, o_done, o_err    status: loading/streaming, end-of-replay pulse, sticky error
module multiexp_pnt_scl_feeder #(
    parameter  int DAT_BITS = 256,
    parameter  int PNT_BITS = 1536,
    parameter  int MAX_IN   = 1024,
    parameter  int CTL_BITS = 8,
    localparam int MOD_BITS = (DAT_BITS / 8 > 1) ? $clog2(DAT_BITS / 8) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [63:0]         i_num_in,
    input  logic                i_load_val,
    output logic                i_load_rdy,
    input  logic                i_load_sop,
    input  logic                i_load_eop,
    input  logic [DAT_BITS-1:0] i_load_dat,
    input  logic [MOD_BITS-1:0] i_load_mod,
    input  logic [CTL_BITS-1:0] i_load_ctl,
    input  logic                i_load_err,
    output logic                o_pnt_scl_val,
    input  logic                o_pnt_scl_rdy,
    output logic                o_pnt_scl_sop,
    output logic                o_pnt_scl_eop,
    output logic [DAT_BITS-1:0] o_pnt_scl_dat,
    output logic [MOD_BITS-1:0] o_pnt_scl_mod,
    output logic [CTL_BITS-1:0] o_pnt_scl_ctl,
    output logic                o_pnt_scl_err,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int BEATS  = (DAT_BITS + PNT_BITS) / DAT_BITS;
    localparam int DEPTH  = MAX_IN * BEATS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = $clog2(DEPTH + 1);
    localparam int N_W    = $clog2(MAX_IN + 1);
    localparam int PASS_W = $clog2(DAT_BITS + 1);
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    typedef struct packed {
        logic [DAT_BITS-1:0] dat;
        logic                sop;
        logic                eop;
        logic                last;   // final beat of the final pass
    } beat_t;

    state_t state_q, state_d;

    logic [DAT_BITS-1:0] mem [DEPTH];
    logic [DAT_BITS-1:0] ram_dat;

    logic [PTR_W-1:0]  n_tot;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [BEAT_W-1:0] wr_beat, rd_beat;
    logic [PASS_W-1:0] pass;
    logic              rd_fin;
    logic              ram_vld, ram_sop, ram_eop, ram_last;
    logic              out_vld, skid_vld;
    beat_t             out_b, skid_b, ram_b;
    logic              done_q, err_q;

    logic       start_ok, load_fire, frame_bad, load_last;
    logic       pop, fin_pop, rd_en, rd_wrap, rd_last;
    logic [1:0] occ, occ_left;

    assign start_ok  = i_start && (state_q == IDLE) &&
                       (i_num_in != 64'd0) && (i_num_in <= 64'(MAX_IN));
    assign load_fire = (state_q == LOAD) && i_load_val;
    assign frame_bad = load_fire &&
                       ((i_load_sop != (wr_beat == '0)) ||
                        (i_load_eop != (wr_beat == BEAT_W'(BEATS - 1))));
    assign load_last = load_fire && (wr_ptr == n_tot - PTR_W'(1));

    assign pop     = out_vld && o_pnt_scl_rdy;
    assign fin_pop = pop && out_b.last;

    // Every issued read lands in ram_b one cycle later and must find a slot in
    // out/skid on the following edge, so only issue while at most one entry
    // remains after this cycle's pop. Steady state (out + ram full, pop=1) still issues.
    assign occ      = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, ram_vld};
    assign occ_left = occ - {1'b0, pop};
    assign rd_en    = (state_q == STREAM) && !rd_fin && (occ_left <= 2'd1);
    assign rd_wrap  = (rd_ptr == n_tot - PTR_W'(1));
    assign rd_last  = rd_wrap && (pass == PASS_W'(DAT_BITS - 1));

    assign ram_b = {ram_dat, ram_sop, ram_eop, ram_last};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (frame_bad) state_d = IDLE;
                     else if (load_last) state_d = STREAM;
            STREAM:  if (fin_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        i_load_rdy    = (state_q == LOAD);
        o_busy        = (state_q != IDLE);
        o_done        = done_q;
        o_err         = err_q;
        o_pnt_scl_val = out_vld;
        o_pnt_scl_sop = out_b.sop;
        o_pnt_scl_eop = out_b.eop;
        o_pnt_scl_dat = out_b.dat;
        o_pnt_scl_mod = '0;
        o_pnt_scl_ctl = '0;
        o_pnt_scl_err = 1'b0;
    end

    // Word RAM, one-cycle synchronous read
    always_ff @(posedge i_clk) begin
        if (load_fire) mem[wr_ptr[ADDR_W-1:0]] <= i_load_dat;
        if (rd_en)     ram_dat <= mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            n_tot    <= '0;
            wr_ptr   <= '0;
            wr_beat  <= '0;
            rd_ptr   <= '0;
            rd_beat  <= '0;
            pass     <= '0;
            rd_fin   <= 1'b0;
            ram_vld  <= 1'b0;
            ram_sop  <= 1'b0;
            ram_eop  <= 1'b0;
            ram_last <= 1'b0;
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_b    <= '0;
            skid_b   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= (state_q == STREAM) && fin_pop;

            if (i_start && (state_q == IDLE)) err_q <= !start_ok;
            else if (frame_bad)               err_q <= 1'b1;

            if (start_ok) begin
                n_tot   <= PTR_W'(i_num_in[N_W-1:0]) * PTR_W'(BEATS);
                wr_ptr  <= '0;
                wr_beat <= '0;
                rd_ptr  <= '0;
                rd_beat <= '0;
                pass    <= '0;
                rd_fin  <= 1'b0;
            end

            if (load_fire) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                wr_beat <= (wr_beat == BEAT_W'(BEATS - 1)) ? '0 : wr_beat + BEAT_W'(1);
            end

            if (rd_en) begin
                if (rd_wrap) begin
                    rd_ptr  <= '0;
                    rd_beat <= '0;
                    pass    <= pass + PASS_W'(1);
                    rd_fin  <= rd_last;
                end else begin
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                    rd_beat <= (rd_beat == BEAT_W'(BEATS - 1)) ? '0 : rd_beat + BEAT_W'(1);
                end
            end

            ram_vld  <= rd_en;
            ram_sop  <= (rd_beat == '0);
            ram_eop  <= (rd_beat == BEAT_W'(BEATS - 1));
            ram_last <= rd_last;

            // Output register refills from skid first so beat order is preserved.
            if (state_q != STREAM) begin
                out_vld  <= 1'b0;
                skid_vld <= 1'b0;
            end else if (!out_vld || pop) begin
                if (skid_vld) begin
                    out_b    <= skid_b;
                    out_vld  <= 1'b1;
                    skid_b   <= ram_b;
                    skid_vld <= ram_vld;
                end else begin
                    out_b    <= ram_b;
                    out_vld  <= ram_vld;
                end
            end else if (ram_vld) begin
                skid_b   <= ram_b;
                skid_vld <= 1'b1;
            end
        end
    end

    logic unused_load_side;
    assign unused_load_side = ^{i_load_mod, i_load_ctl, i_load_err};

endmodule
